// File: rtl/microsequencer_param_if.sv
// Sequencer-facing bundle for microsequencer_param: microinstruction fields in,
// state/stack/loop/fault status out. master = microstore side, slave = sequencer.
interface microsequencer_param_if #(
  parameter int STATE_W     = 10,
  parameter int NCOND       = 4,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 8
);
  localparam int SEL_W = (NCOND > 1) ? $clog2(NCOND) : 1;
  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  logic [2:0]         ns_op;
  logic [SEL_W-1:0]   cond_sel;
  logic               cond_inv;
  logic [STATE_W-1:0] target;
  logic [STATE_W-1:0] ir_entry;
  logic [NCOND-1:0]   cond_in;
  logic               cnt_ld;
  logic [CNT_W-1:0]   cnt_val;
  logic [STATE_W-1:0] current_state;
  logic [STATE_W-1:0] next_state;
  logic [LVL_W-1:0]   stack_level;
  logic               loop_zero;
  logic               fault;
  logic [1:0]         fault_code;

  modport master (
    output ns_op, cond_sel, cond_inv, target, ir_entry, cond_in, cnt_ld, cnt_val,
    input  current_state, next_state, stack_level, loop_zero, fault, fault_code
  );

  modport slave (
    input  ns_op, cond_sel, cond_inv, target, ir_entry, cond_in, cnt_ld, cnt_val,
    output current_state, next_state, stack_level, loop_zero, fault, fault_code
  );
endinterface

// File: rtl/microsequencer_param.sv
// Parametrised microsequencer: return stack, loop counter, WAIT and sticky faults.
// Optional WAIT watchdog is compiled in with `define MSEQ_WATCHDOG_EN.
module microsequencer_param #(
  parameter int STATE_W     = 10,
  parameter int NCOND       = 4,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 8,
  parameter int RESET_STATE = 0,
  parameter int FAULT_STATE = 1,
  parameter int WDOG_LIMIT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  microsequencer_param_if.slave bus
);
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    OP_INC, OP_JMP, OP_DISPATCH, OP_CJMP, OP_CALL, OP_RET, OP_LOOP, OP_WAIT
  } ns_op_t;

  logic [STATE_W-1:0] state_reg, state_next, inc;
  logic [LVL_W-1:0]   level_reg, level_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               fault_reg;
  logic [1:0]         code_reg;
  logic [1:0]         fault_kind;
  logic               push, cond_eff, stalling, wd_trip;
  logic [STATE_W-1:0] stack_mem [STACK_DEPTH];

  assign cond_eff = bus.cond_in[bus.cond_sel] ^ bus.cond_inv;
  assign stalling = (bus.ns_op == OP_WAIT) && !cond_eff;

`ifdef MSEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  logic [WD_W-1:0] wd_reg;

  assign wd_trip = stalling && (wd_reg == WD_W'(WDOG_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wd_reg <= '0;
    else if (stalling && !wd_trip)
      wd_reg <= wd_reg + WD_W'(1);
    else
      wd_reg <= '0;
  end
`else
  // Never trips when the watchdog is compiled out.
  assign wd_trip = stalling && (WDOG_LIMIT < 0);
`endif

  always_comb begin
    inc        = state_reg + STATE_W'(1);
    state_next = inc;
    level_next = level_reg;
    cnt_next   = cnt_reg;
    push       = 1'b0;
    fault_kind = 2'b00;
    unique case (ns_op_t'(bus.ns_op))
      OP_INC:      ;
      OP_JMP:      state_next = bus.target;
      OP_DISPATCH: state_next = bus.ir_entry;
      OP_CJMP:     if (cond_eff) state_next = bus.target;
      OP_CALL: begin
        if (level_reg == LVL_W'(STACK_DEPTH)) begin
          fault_kind = 2'b01;
        end else begin
          push       = 1'b1;
          level_next = level_reg + LVL_W'(1);
          state_next = bus.target;
        end
      end
      OP_RET: begin
        if (level_reg == '0) begin
          fault_kind = 2'b10;
        end else begin
          level_next = level_reg - LVL_W'(1);
          state_next = stack_mem[PTR_W'(level_reg - LVL_W'(1))];
        end
      end
      OP_LOOP: begin
        if (cnt_reg != '0) begin
          cnt_next   = cnt_reg - CNT_W'(1);
          state_next = bus.target;
        end
      end
      OP_WAIT:     if (stalling) state_next = state_reg;
    endcase
    if (wd_trip)
      fault_kind = 2'b11;
    if (fault_kind != 2'b00)
      state_next = STATE_W'(FAULT_STATE);
    // A load wins over the decrement, but the LOOP above already used the old count.
    if (bus.cnt_ld)
      cnt_next = bus.cnt_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= STATE_W'(RESET_STATE);
      level_reg <= '0;
      cnt_reg   <= '0;
      fault_reg <= 1'b0;
      code_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
      if (fault_kind != 2'b00 && !fault_reg) begin
        fault_reg <= 1'b1;
        code_reg  <= fault_kind;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset)
      stack_mem[level_reg[PTR_W-1:0]] <= inc;
  end

  assign bus.current_state = state_reg;
  assign bus.next_state    = state_next;
  assign bus.stack_level   = level_reg;
  assign bus.loop_zero     = (cnt_reg == '0);
  assign bus.fault         = fault_reg;
  assign bus.fault_code    = code_reg;
endmodule

// File: tb/tb_microsequencer_param.sv
// Bench for microsequencer_param: directed plan steps then random ops, two widths
// (STATE_W=4 and 10) checked against an array-based behavioural model.
module tb_microsequencer_param;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] op = '0;
  logic [1:0] sel = '0;
  logic       inv = 1'b0;
  logic [9:0] tgt = '0;
  logic [9:0] ir = '0;
  logic [3:0] cin = '0;
  logic       ld = 1'b0;
  logic [7:0] cval = '0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  microsequencer_param_if #(.STATE_W(4))  if4 ();
  microsequencer_param_if #(.STATE_W(10)) if10 ();

  assign if4.ns_op     = op;      assign if10.ns_op    = op;
  assign if4.cond_sel  = sel;     assign if10.cond_sel = sel;
  assign if4.cond_inv  = inv;     assign if10.cond_inv = inv;
  assign if4.target    = tgt[3:0]; assign if10.target  = tgt;
  assign if4.ir_entry  = ir[3:0]; assign if10.ir_entry = ir;
  assign if4.cond_in   = cin;     assign if10.cond_in  = cin;
  assign if4.cnt_ld    = ld;      assign if10.cnt_ld   = ld;
  assign if4.cnt_val   = cval;    assign if10.cnt_val  = cval;

  microsequencer_param #(.STATE_W(4), .WDOG_LIMIT(4)) dut4 (
    .clk(clk), .reset(reset), .bus(if4.slave)
  );
  microsequencer_param #(.STATE_W(10), .WDOG_LIMIT(4)) dut10 (
    .clk(clk), .reset(reset), .bus(if10.slave)
  );

  // Behavioural model, index 0 = 4-bit instance, 1 = 10-bit instance
  int m_state[2], m_lvl[2], m_cnt[2], m_fault[2], m_code[2], m_wd[2];
  int m_stk[2][4];
  int p_state[2], p_lvl[2], p_cnt[2], p_fault[2], p_code[2], p_wd[2];
  int p_push[2], p_pushval[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_lvl[k] = 0; m_cnt[k] = 0;
      m_fault[k] = 0; m_code[k] = 0; m_wd[k] = 0;
    end
  endtask

  task automatic model_eval(input int k);
    int mask, inc, ns, fk, c;
    mask = (k == 0) ? 15 : 1023;
    c    = int'(cin[sel] ^ inv);
    inc  = (m_state[k] + 1) & mask;
    ns = inc; fk = 0;
    p_lvl[k] = m_lvl[k]; p_cnt[k] = m_cnt[k]; p_push[k] = 0; p_pushval[k] = inc;
    case (op)
      3'd1: ns = int'(tgt) & mask;
      3'd2: ns = int'(ir) & mask;
      3'd3: if (c != 0) ns = int'(tgt) & mask;
      3'd4: if (m_lvl[k] == 4) fk = 1;
            else begin p_push[k] = 1; p_lvl[k] = m_lvl[k] + 1; ns = int'(tgt) & mask; end
      3'd5: if (m_lvl[k] == 0) fk = 2;
            else begin p_lvl[k] = m_lvl[k] - 1; ns = m_stk[k][m_lvl[k] - 1]; end
      3'd6: if (m_cnt[k] != 0) begin p_cnt[k] = m_cnt[k] - 1; ns = int'(tgt) & mask; end
      3'd7: if (c == 0) ns = m_state[k];
      default: ;
    endcase
    p_wd[k] = 0;
`ifdef MSEQ_WATCHDOG_EN
    if (op == 3'd7 && c == 0) begin
      if (m_wd[k] == 4) fk = 3;
      else p_wd[k] = m_wd[k] + 1;
    end
`endif
    if (fk != 0) ns = 1;
    if (ld) p_cnt[k] = int'(cval);
    p_state[k] = ns;
    p_fault[k] = m_fault[k]; p_code[k] = m_code[k];
    if (fk != 0 && m_fault[k] == 0) begin p_fault[k] = 1; p_code[k] = fk; end
  endtask

  task automatic model_commit(input int k);
    if (p_push[k] != 0) m_stk[k][m_lvl[k]] = p_pushval[k];
    m_state[k] = p_state[k]; m_lvl[k] = p_lvl[k]; m_cnt[k] = p_cnt[k];
    m_fault[k] = p_fault[k]; m_code[k] = p_code[k]; m_wd[k] = p_wd[k];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "/state4"}, 32'(if4.current_state), m_state[0]);
    chk({tag, "/level4"}, 32'(if4.stack_level), m_lvl[0]);
    chk({tag, "/lz4"},    32'(if4.loop_zero), (m_cnt[0] == 0) ? 1 : 0);
    chk({tag, "/fault4"}, 32'(if4.fault), m_fault[0]);
    chk({tag, "/code4"},  32'(if4.fault_code), m_code[0]);
    chk({tag, "/state10"}, 32'(if10.current_state), m_state[1]);
    chk({tag, "/level10"}, 32'(if10.stack_level), m_lvl[1]);
    chk({tag, "/lz10"},    32'(if10.loop_zero), (m_cnt[1] == 0) ? 1 : 0);
    chk({tag, "/fault10"}, 32'(if10.fault), m_fault[1]);
    chk({tag, "/code10"},  32'(if10.fault_code), m_code[1]);
  endtask

  // Called 1 time unit after a rising edge; asserts reset between edges.
  task automatic do_reset(input string tag);
    #1 reset = 1'b1;
    #1 model_reset();
    check_regs(tag);
    @(posedge clk);
    #1 reset = 1'b0;
    $display("txn %s: reset", tag);
  endtask

  task automatic step(input string tag);
    model_eval(0);
    model_eval(1);
    #3;
    chk({tag, "/next4"},  32'(if4.next_state), p_state[0]);
    chk({tag, "/next10"}, 32'(if10.next_state), p_state[1]);
    @(posedge clk);
    model_commit(0);
    model_commit(1);
    #1 check_regs(tag);
    $display("txn %s: op=%0d tgt=%0d c_in=%b ld=%0d -> s4=%0d s10=%0d lvl=%0d code=%0d",
             tag, op, tgt, cin, ld, if4.current_state, if10.current_state,
             if10.stack_level, if10.fault_code);
  endtask

  task automatic set_op(input logic [2:0] o, input logic [9:0] t);
    op = o; tgt = t; ld = 1'b0; cin = '0; inv = 1'b0; sel = '0;
  endtask

  initial begin
    #1;
    do_reset("init");

    // INC wrap on the 4-bit instance
    for (int i = 1; i <= 17; i++) begin
      set_op(3'd0, 10'd0);
      step("inc_wrap");
      chk("inc_wrap/explicit", 32'(if4.current_state), i % 16);
    end

    // CALL/RET nesting
    do_reset("nest");
    set_op(3'd1, 10'd5);  step("nest_jmp");  chk("nest/s5", 32'(if10.current_state), 5);
    set_op(3'd4, 10'd20); step("nest_call1"); chk("nest/s20", 32'(if10.current_state), 20);
    chk("nest/l1", 32'(if10.stack_level), 1);
    set_op(3'd4, 10'd40); step("nest_call2"); chk("nest/s40", 32'(if10.current_state), 40);
    chk("nest/l2", 32'(if10.stack_level), 2);
    set_op(3'd5, 10'd0);  step("nest_ret1");  chk("nest/s21", 32'(if10.current_state), 21);
    set_op(3'd5, 10'd0);  step("nest_ret2");  chk("nest/s6", 32'(if10.current_state), 6);
    chk("nest/l0", 32'(if10.stack_level), 0);
    chk("nest/nofault", 32'(if10.fault), 0);

    // Overflow on 5th CALL, then underflow after reset
    for (int i = 0; i < 5; i++) begin
      set_op(3'd4, 10'd20);
      step("ovf_call");
    end
    chk("ovf/state", 32'(if10.current_state), 1);
    chk("ovf/code", 32'(if10.fault_code), 1);
    chk("ovf/level", 32'(if10.stack_level), 4);
    do_reset("unf");
    set_op(3'd5, 10'd0); step("unf_ret");
    chk("unf/state", 32'(if10.current_state), 1);
    chk("unf/code", 32'(if10.fault_code), 2);

    // Loop counter
    do_reset("loop");
    set_op(3'd1, 10'd8); ld = 1'b1; cval = 8'd3; step("loop_ld");
    for (int i = 0; i < 3; i++) begin
      set_op(3'd6, 10'd8); step("loop_taken");
      chk("loop/held8", 32'(if10.current_state), 8);
    end
    chk("loop/zero", 32'(if10.loop_zero), 1);
    set_op(3'd6, 10'd8); step("loop_exit");
    chk("loop/s9", 32'(if10.current_state), 9);
    set_op(3'd1, 10'd8); step("loop_back");
    set_op(3'd6, 10'd8); ld = 1'b1; cval = 8'd5; step("loop_collide");
    chk("collide/s9", 32'(if10.current_state), 9);
    chk("collide/nz", 32'(if10.loop_zero), 0);

    // WAIT on MOC
    do_reset("wait");
    set_op(3'd1, 10'd12); step("wait_jmp");
    for (int i = 0; i < 3; i++) begin
      set_op(3'd7, 10'd0); step("wait_stall");
      chk("wait/held12", 32'(if10.current_state), 12);
    end
    set_op(3'd7, 10'd0); cin = 4'b0001; step("wait_go");
    chk("wait/s13", 32'(if10.current_state), 13);
    set_op(3'd1, 10'd12); step("wait_jmp2");
    set_op(3'd7, 10'd0); inv = 1'b1; step("wait_inv");
    chk("wait_inv/s13", 32'(if10.current_state), 13);

    // DISPATCH
    set_op(3'd2, 10'd0); ir = 10'h155; step("dispatch");
    chk("dispatch/explicit", 32'(if10.current_state), 10'h155);

    // Long stall: watchdog trips only when compiled in
    do_reset("wdog");
    set_op(3'd1, 10'd12); step("wdog_jmp");
    for (int i = 0; i < 8; i++) begin
      set_op(3'd7, 10'd0); step("wdog_stall");
    end
`ifdef MSEQ_WATCHDOG_EN
    chk("wdog/state", 32'(if10.current_state), 1);
    chk("wdog/code", 32'(if10.fault_code), 3);
`else
    chk("wdog/state", 32'(if10.current_state), 12);
    chk("wdog/fault", 32'(if10.fault), 0);
`endif

    // Random operation mix
    do_reset("rand");
    for (int i = 0; i < 400; i++) begin
      op   = 3'($urandom_range(7));
      sel  = 2'($urandom_range(3));
      inv  = 1'($urandom_range(1));
      tgt  = 10'($urandom);
      ir   = 10'($urandom);
      cin  = 4'($urandom);
      ld   = ($urandom_range(7) == 0);
      cval = 8'($urandom_range(6));
      step("rand");
      if ($urandom_range(63) == 0) do_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
